// File: rtl/shifter_pkg.sv
// Shared encodings for the right/left shifter datapath blocks.
// Mode codes and control FSM states live here so both directions agree.
package shifter_pkg;

    localparam logic [1:0] SHMODE_LSR = 2'b00;
    localparam logic [1:0] SHMODE_ASR = 2'b01;
    localparam logic [1:0] SHMODE_ROR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_e;

endpackage

// File: rtl/shift_step_r.sv
// Combinational one-bit right step: logical, arithmetic or rotate.
// Mode 2'b11 falls through to rotate as an alias.
module shift_step_r
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] r_next
);

    always_comb begin
        r_next = r;
        case (mode)
            SHMODE_LSR: r_next = {1'b0, r[WIDTH-1:1]};
            SHMODE_ASR: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
            default:    r_next = {r[0], r[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter/rotator, one bit per clock,
// with valid/ready on both sides and a held result.
module seq_right_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic [1:0]       shift_mode,
    input  logic [AMT_W-1:0] shift_amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             busy
);

    sh_state_e        state_q, state_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] step_r;

    shift_step_r #(.WIDTH(WIDTH)) u_step (
        .r      (work_q),
        .mode   (mode_q),
        .r_next (step_r)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mode_d      = mode_q;
        work_d      = work_q;
        d_out_d     = d_out_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mode_d     = shift_mode;
                    work_d     = d_in;
                    count_d    = shift_amount;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (shift_amount == '0) begin
                        state_d     = ST_DONE;
                        d_out_d     = d_in;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = step_r;
                count_d = count_q - AMT_W'(1);
                // Last step lands straight in the output register.
                if (count_q == AMT_W'(1)) begin
                    state_d     = ST_DONE;
                    d_out_d     = step_r;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            mode_q      <= '0;
            work_q      <= '0;
            d_out_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            work_q      <= work_d;
            d_out_q     <= d_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d_out     = d_out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter: vector table plus
// backpressure, back-to-back and mid-shift reset sequences.
module tb_seq_right_shifter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d_in;
    logic [1:0] shift_mode;
    logic [2:0] shift_amount;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d_out;
    logic       busy;

    int total;
    int passed;

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic [2:0] a;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    seq_right_shifter #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .d_in         (d_in),
        .shift_mode   (shift_mode),
        .shift_amount (shift_amount),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .d_out        (d_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offer an operand, wait for the accept edge, then scramble inputs.
    task automatic accept(input logic [7:0] d, input logic [1:0] m,
                          input logic [2:0] a);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        d_in = d;
        shift_mode = m;
        shift_amount = a;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 40, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d_in = 8'($urandom);
        shift_mode = 2'($urandom);
        shift_amount = 3'($urandom_range(0, 7));
    endtask

    // Edges counted from the accept edge (inclusive) until out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit stable;
        total = 0;
        passed = 0;

        vecs[0] = '{8'h96, 2'b10, 3'd3, 8'hD2};
        vecs[1] = '{8'h96, 2'b01, 3'd2, 8'hE5};
        vecs[2] = '{8'h96, 2'b00, 3'd2, 8'h25};
        vecs[3] = '{8'h96, 2'b00, 3'd7, 8'h01};
        vecs[4] = '{8'h5A, 2'b01, 3'd0, 8'h5A};
        vecs[5] = '{8'h96, 2'b11, 3'd3, 8'hD2};
        vecs[6] = '{8'h80, 2'b01, 3'd7, 8'hFF};
        vecs[7] = '{8'h81, 2'b10, 3'd1, 8'hC0};
        vecs[8] = '{8'h7F, 2'b01, 3'd7, 8'h00};
        vecs[9] = '{8'hF0, 2'b00, 3'd4, 8'h0F};

        // Reset with noisy inputs
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        d_in = 8'hA5;
        shift_mode = 2'b01;
        shift_amount = 3'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_d_out", d_out, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        // Table vectors, out_ready held high
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            accept(vecs[i].d, vecs[i].m, vecs[i].a);
            check($sformatf("v%0d_busy", i), busy, 1);
            wait_valid(lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].a + 1);
            check($sformatf("v%0d_dout", i), d_out, vecs[i].exp);
            check($sformatf("v%0d_inrdy_done", i), in_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ov_clr", i), out_valid, 0);
            check($sformatf("v%0d_inrdy_idle", i), in_ready, 1);
        end

        // Backpressure, second operand held while blocked
        out_ready = 1'b0;
        accept(8'h96, 2'b10, 3'd3);
        wait_valid(lat);
        check("bp_lat", lat, 4);
        in_valid = 1'b1;
        d_in = 8'h3C;
        shift_mode = 2'b00;
        shift_amount = 3'd1;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!(out_valid && d_out == 8'hD2 && !in_ready && busy))
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_ov", out_valid, 0);
        check("bp_release_inrdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_accepted", busy, 1);
        check("b2b_inrdy", in_ready, 0);
        @(posedge clk);
        #1;
        check("b2b_ov", out_valid, 1);
        check("b2b_dout", d_out, 8'h1E);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_idle", in_ready, 1);

        // Reset during second of five shift steps
        accept(8'hFF, 2'b00, 3'd5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_inrdy", in_ready, 1);
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dout", d_out, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        stable = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) stable = 1'b0;
        end
        check("mid_rst_no_pulse", stable, 1);
        accept(8'hC3, 2'b01, 3'd5);
        wait_valid(lat);
        check("post_rst_lat", lat, 6);
        check("post_rst_dout", d_out, 8'hFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
